// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the emulator-side master and the rtl_adapter slave top.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RSP          = 3'd5
  } mst_state_e;

  // States in which the master is waiting on the slave and the stall budget runs.
  function automatic logic is_busy(mst_state_e s);
    return (s == ST_WR_ADDR_DATA) || (s == ST_WR_RESP) ||
           (s == ST_RD_ADDR)      || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one request/response beat into an AXI read or write.
// DATA_W must be 32 or 64.
module axil_lite_master
  import axil_pkg::*;
#(
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic                  timeout_o,
  input  logic                  timeout_clr,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_W-1:0]     ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [1:0]            RRESP
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  mst_state_e              state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W/8-1:0]     wstrb_q;
  logic                    aw_done_q, w_done_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    rsp_valid_q, rsp_write_q;
  logic [DATA_W-1:0]       rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;
  logic                    aw_fire, w_fire, aw_all, w_all;

  assign aw_fire = awvalid_q & AWREADY;
  assign w_fire  = wvalid_q & WREADY;
  // A channel counts as finished once it handshook earlier or is handshaking now.
  assign aw_all  = aw_done_q | aw_fire;
  assign w_all   = w_done_q | w_fire;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      // NOTE: address/data registers are reset too so the AXI payload buses never show X after reset.
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (req_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_ADDR_DATA;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_ADDR_DATA: begin
          if (aw_fire) awvalid_q <= 1'b0;
          if (w_fire)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_all;
          w_done_q  <= w_all;
          if (aw_all && w_all) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (BVALID && bready_q) begin
            rsp_resp_q  <= BRESP;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b1;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RD_ADDR: begin
          if (arvalid_q && ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (RVALID && rready_q) begin
            rsp_rdata_q <= RDATA;
            rsp_resp_q  <= RRESP;
            rsp_write_q <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall budget: flag is raised once, on the cycle the counter first reaches the limit.
  always_comb begin
    // NOTE: defaults first keep this block free of inferred latches.
    cnt_d     = cnt_q;
    timeout_d = timeout_clr ? 1'b0 : timeout_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (is_busy(state_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if ((TIMEOUT_CYC != 0) && (cnt_d == CNT_MAX)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;
  assign timeout_o = timeout_q;
  assign AWVALID   = awvalid_q;
  assign AWADDR    = addr_q;
  assign WVALID    = wvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign ARADDR    = addr_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axil_lite_master.sv
// Bench for axil_lite_master: scripted AXI-Lite slave with per-channel delays plus latency/response model.
module tb_axil_lite_master;

  localparam int TO_CYC = 8;

  logic        ACLK, ARESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_o, timeout_clr;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  axil_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .timeout_o(timeout_o), .timeout_clr(timeout_clr),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- slave configuration (written by the stimulus only) ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  resp_v = 2'b00;
  logic [31:0] rdata_v = 32'h0;

  // ---------------- slave state (written by the slave only) ----------------
  bit          aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  int          n_aw = 0, n_w = 0, n_ar = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  bit          aw_pend = 0, w_pend = 0, ar_pend = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [31:0] pend_awaddr = 0, pend_wdata = 0, pend_araddr = 0;

  // Slave and protocol monitor act on the falling edge; the DUT samples on the rising edge.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      BRESP = 0; RRESP = 0; RDATA = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
    end else begin
      if (aw_pend) begin
        check("awvalid_held", AWVALID, 1);
        check("awaddr_stable", AWADDR, pend_awaddr);
      end
      if (w_pend) begin
        check("wvalid_held", WVALID, 1);
        check("wdata_stable", WDATA, pend_wdata);
      end
      if (ar_pend) begin
        check("arvalid_held", ARVALID, 1);
        check("araddr_stable", ARADDR, pend_araddr);
      end
      if (aw_hs) check("awvalid_drop", AWVALID, 0);
      if (w_hs)  check("wvalid_drop", WVALID, 0);
      if (ar_hs) check("arvalid_drop", ARVALID, 0);
      if (BREADY) check("bready_after_aw_w", aw_got && w_got, 1);

      if (b_fire) begin
        BVALID = 0; b_fire = 0; aw_got = 0; w_got = 0; b_wait = 0;
      end else if (aw_got && w_got && !BVALID) begin
        if (b_wait >= b_dly) begin BVALID = 1; BRESP = resp_v; end
        else b_wait++;
      end
      if (BVALID && BREADY) b_fire = 1;

      if (r_fire) begin
        RVALID = 0; r_fire = 0; ar_got = 0; r_wait = 0;
      end else if (ar_got && !RVALID) begin
        if (r_wait >= r_dly) begin RVALID = 1; RDATA = rdata_v; RRESP = resp_v; end
        else r_wait++;
      end
      if (RVALID && RREADY) r_fire = 1;

      aw_hs = 0;
      if (AWVALID && !aw_got) begin
        AWREADY = (aw_wait >= aw_dly);
        if (AWREADY) begin aw_got = 1; aw_hs = 1; aw_wait = 0; cap_awaddr = AWADDR; n_aw++; end
        else aw_wait++;
      end else AWREADY = 0;
      aw_pend = AWVALID && !AWREADY; pend_awaddr = AWADDR;

      w_hs = 0;
      if (WVALID && !w_got) begin
        WREADY = (w_wait >= w_dly);
        if (WREADY) begin w_got = 1; w_hs = 1; w_wait = 0; cap_wdata = WDATA; cap_wstrb = WSTRB; n_w++; end
        else w_wait++;
      end else WREADY = 0;
      w_pend = WVALID && !WREADY; pend_wdata = WDATA;

      ar_hs = 0;
      if (ARVALID && !ar_got) begin
        ARREADY = (ar_wait >= ar_dly);
        if (ARREADY) begin ar_got = 1; ar_hs = 1; ar_wait = 0; cap_araddr = ARADDR; n_ar++; end
        else ar_wait++;
      end else ARREADY = 0;
      ar_pend = ARVALID && !ARREADY; pend_araddr = ARADDR;
    end
  end

  // ---------------- vectors and reference model ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;
    int          exp_lat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  // Latency counts cycles from acceptance: each channel handshakes one cycle after its
  // delay elapses, the response channel opens the cycle after, and rsp_valid follows it.
  function automatic vec_t apply_model(vec_t v);
    int addr_phase;
    if (v.wr) begin
      addr_phase = 1 + ((v.aw_d > v.w_d) ? v.aw_d : v.w_d);
      v.exp_lat  = addr_phase + 2 + v.b_d;
      v.exp_rdata = 32'h0;
    end else begin
      v.exp_lat  = 3 + v.ar_d + v.r_d;
      v.exp_rdata = v.rdata;
    end
    v.exp_resp = v.resp;
    v.exp_to   = ((v.exp_lat - 1) >= TO_CYC);
    return v;
  endfunction

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int lat, base_aw, base_w, base_ar;
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
    resp_v = v.resp; rdata_v = v.rdata;
    base_aw = n_aw; base_w = n_w; base_ar = n_ar;
    tick();
    check($sformatf("%s/req_ready_idle", tag), req_ready, 1);
    req_valid = 1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    tick();
    req_valid = 0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_wstrb = ~v.wstrb;
    check($sformatf("%s/req_ready_busy", tag), req_ready, 0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check($sformatf("%s/latency", tag), lat, v.exp_lat);
    check($sformatf("%s/rsp_resp", tag), rsp_resp, v.exp_resp);
    check($sformatf("%s/rsp_rdata", tag), rsp_rdata, v.exp_rdata);
    check($sformatf("%s/rsp_write", tag), rsp_write, v.wr);
    check($sformatf("%s/timeout", tag), timeout_o, v.exp_to);
    if (v.wr) begin
      check($sformatf("%s/aw_count", tag), n_aw - base_aw, 1);
      check($sformatf("%s/w_count", tag), n_w - base_w, 1);
      check($sformatf("%s/awaddr", tag), cap_awaddr, v.addr);
      check($sformatf("%s/wdata", tag), cap_wdata, v.wdata);
      check($sformatf("%s/wstrb", tag), cap_wstrb, v.wstrb);
    end else begin
      check($sformatf("%s/ar_count", tag), n_ar - base_ar, 1);
      check($sformatf("%s/araddr", tag), cap_araddr, v.addr);
    end
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check($sformatf("%s/hold_valid", tag), rsp_valid, 1);
      check($sformatf("%s/hold_rdata", tag), rsp_rdata, v.exp_rdata);
      check($sformatf("%s/hold_resp", tag), rsp_resp, v.exp_resp);
      check($sformatf("%s/hold_req_ready", tag), req_ready, 0);
    end
    rsp_ready = 1;
    check($sformatf("%s/req_ready_in_rsp", tag), req_ready, 0);
    tick();
    rsp_ready = 0;
    check($sformatf("%s/rsp_valid_clear", tag), rsp_valid, 0);
    check($sformatf("%s/req_ready_after", tag), req_ready, 1);
    if (timeout_o === 1'b1) begin
      timeout_clr = 1;
      tick();
      timeout_clr = 0;
      check($sformatf("%s/timeout_clr", tag), timeout_o, 0);
    end
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 0; timeout_clr = 0;
    tick(); tick();
    check("rst/AWVALID", AWVALID, 0);
    check("rst/WVALID", WVALID, 0);
    check("rst/ARVALID", ARVALID, 0);
    check("rst/BREADY", BREADY, 0);
    check("rst/RREADY", RREADY, 0);
    check("rst/rsp_valid", rsp_valid, 0);
    check("rst/timeout_o", timeout_o, 0);
    check("rst/rsp_payload", {rsp_rdata, rsp_resp, rsp_write}, 0);
    check("rst/req_ready", req_ready, 1);
    ARESETn = 1;

    //              wr    addr         wdata         wstrb aw w  b  ar r  resp   rdata         hold lat resp   exp_rdata     to
    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 0, 3, 2'b00, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 32'h14,  32'hCAFEF00D, 4'h3, 0, 3, 0, 0, 0, 2'b10, 32'hFFFFFFFF, 1, 6, 2'b10, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 32'h20,  32'h0,        4'h0, 0, 0, 0, 2, 0, 2'b00, 32'h12345678, 4, 5, 2'b00, 32'h12345678, 1'b0};
    tbl[3] = '{1'b0, 32'h44,  32'h0,        4'h0, 0, 0, 0, 0, 2, 2'b11, 32'hA5A5A5A5, 2, 5, 2'b11, 32'hA5A5A5A5, 1'b0};
    tbl[4] = '{1'b1, 32'h100, 32'h0BADF00D, 4'h5, 2, 0, 1, 0, 0, 2'b01, 32'h00000001, 0, 6, 2'b01, 32'h0,        1'b0};
    tbl[5] = '{1'b1, 32'h104, 32'h11112222, 4'h8, 3, 3, 3, 0, 0, 2'b00, 32'h0,        0, 9, 2'b00, 32'h0,        1'b1};
    tbl[6] = '{1'b0, 32'h108, 32'h0,        4'h0, 0, 0, 0, 3, 3, 2'b00, 32'h55AA55AA, 1, 9, 2'b00, 32'h55AA55AA, 1'b1};
    tbl[7] = '{1'b0, 32'h10C, 32'h0,        4'h0, 0, 0, 0, 3, 2, 2'b10, 32'h0F0F0F0F, 0, 8, 2'b10, 32'h0F0F0F0F, 1'b0};
    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      rv.wr    = 1'($urandom_range(0, 1));
      rv.addr  = $urandom & 32'hFFFF_FFFC;
      rv.wdata = $urandom;
      rv.wstrb = 4'($urandom_range(1, 15));
      rv.aw_d  = $urandom_range(0, 3);
      rv.w_d   = $urandom_range(0, 3);
      rv.b_d   = $urandom_range(0, 3);
      rv.ar_d  = $urandom_range(0, 3);
      rv.r_d   = $urandom_range(0, 3);
      rv.resp  = 2'($urandom_range(0, 3));
      rv.rdata = $urandom;
      rv.hold  = $urandom_range(0, 3);
      run_txn(apply_model(rv), $sformatf("rnd%0d", i));
    end

    // Slave never accepts the read address: flag rises after TO_CYC stalled cycles.
    ar_dly = 1000000; r_dly = 0; resp_v = 2'b00; rdata_v = 32'hCAFE0001;
    tick();
    req_valid = 1; req_write = 0; req_addr = 32'h80;
    tick();
    req_valid = 0;
    for (int c = 1; c < TO_CYC; c++) tick();
    check("to/before_limit", timeout_o, 0);
    check("to/arvalid_stuck", ARVALID, 1);
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    check("to/set_beats_clear", timeout_o, 1);
    check("to/arvalid_still", ARVALID, 1);
    tick();
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    check("to/cleared", timeout_o, 0);
    check("to/araddr", ARADDR, 32'h80);
    tick(); tick();
    check("to/no_reset_while_saturated", timeout_o, 0);
    ar_dly = 0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    check("to/rsp_valid", rsp_valid, 1);
    check("to/rsp_rdata", rsp_rdata, 32'hCAFE0001);
    check("to/rsp_write", rsp_write, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("to/idle", req_ready, 1);

    // Reset while waiting for the write response abandons the transaction.
    aw_dly = 0; w_dly = 0; b_dly = 1000000;
    tick();
    req_valid = 1; req_write = 1; req_addr = 32'h200; req_wdata = 32'h01020304; req_wstrb = 4'hF;
    tick();
    req_valid = 0;
    tick();
    check("rstmid/in_wr_resp", BREADY, 1);
    #2 ARESETn = 0;
    #1;
    check("rstmid/AWVALID", AWVALID, 0);
    check("rstmid/WVALID", WVALID, 0);
    check("rstmid/BREADY", BREADY, 0);
    check("rstmid/rsp_valid", rsp_valid, 0);
    check("rstmid/req_ready", req_ready, 1);
    tick();
    ARESETn = 1;
    check("rstmid/no_rsp", rsp_valid, 0);
    rv = '{1'b0, 32'h300, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h89ABCDEF, 0, 3, 2'b00, 32'h89ABCDEF, 1'b0};
    run_txn(rv, "post_reset_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
